// File: rtl/golden_nonce_uart_tx.sv
// Queues golden nonces from the hash core and transmits each one as four 8N1 UART bytes
// on txd, least-significant byte first.
module golden_nonce_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic               hash_clk,
    input  logic               reset,
    input  logic [31:0]        golden_nonce,
    input  logic               golden_nonce_match,
    output logic               txd,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]    BIT_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] FULL       = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [31:0]        shift_q, shift_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic               overflow_q, overflow_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]        mem [FIFO_DEPTH];
    logic               pop, push, bit_done;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        txd_d      = txd_q;
        overflow_d = overflow_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        // A pop on the same edge frees a slot, so a strobe into a full FIFO is still taken.
        pop      = (state_q == IDLE) && (count_q != '0);
        push     = golden_nonce_match && ((count_q != FULL) || pop);
        bit_done = (timer_q == '0);

        if (golden_nonce_match && !push) overflow_d = 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (state_q != IDLE) timer_d = bit_done ? BIT_RELOAD : timer_q - TW'(1);

        // txd_d always carries the line level for the state being entered.
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (pop) begin
                    shift_d    = mem[rd_ptr_q];
                    byte_idx_d = 2'd0;
                    timer_d    = BIT_RELOAD;
                    txd_d      = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        txd_d      = 1'b0;
                        state_d    = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (push) mem[wr_ptr_q] <= golden_nonce;
    end

    assign txd        = txd_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/golden_nonce_uart_tx.md
Name: golden_nonce_uart_tx

Overview:
- Consumes the one-cycle golden nonce strobe and 32-bit golden nonce produced by the hash core.
- Buffers nonces in a small FIFO and transmits each one as four 8N1 UART bytes on a single serial line to the host.
- Sits between the hash core(s) and the board's serial TX pin, in the hash clock domain.
- Guarantees that back-to-back matches are never lost while a frame is in flight, unless the FIFO overflows.

Parameters:
- CLKS_PER_BIT, 868, hash_clk cycles per UART bit; minimum 2.
- FIFO_DEPTH, 4, nonce FIFO entries; power of two, minimum 2.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- hash_clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- golden_nonce  input  32  nonce value; sampled only when golden_nonce_match=1.
- golden_nonce_match  input  1  one-cycle strobe; qualifies golden_nonce.
- txd  output  1  UART line; idles high.
- busy  output  1  high while a frame is transmitting or the FIFO is non-empty.
- fifo_count  output  FIFO_AW+1  number of queued nonces, 0..FIFO_DEPTH.
- overflow  output  1  sticky; set when a strobe arrives with the FIFO full.

Behaviour:
- Reset (async assert, released synchronously on hash_clk):
  - txd=1, busy=0, fifo_count=0, overflow=0.
  - FIFO pointers=0, FSM=IDLE, bit and byte counters=0.
  - Asserting reset mid-frame forces txd high immediately and discards all queued nonces.
- FIFO write:
  - On an edge with golden_nonce_match=1 and fifo_count<FIFO_DEPTH, write golden_nonce at wr_ptr.
  - Pointers wrap modulo FIFO_DEPTH.
  - If full, drop the new nonce, set overflow=1, and leave FIFO contents unchanged.
  - overflow clears only on reset.
- FIFO read: occurs only in IDLE when fifo_count>0.
- Simultaneous push and pop in one edge: both take effect and fifo_count is unchanged. When the FIFO is full, a pop on the same edge frees the slot, so the push is accepted and overflow is not set.
- FSM states:
  - IDLE: txd=1. If fifo_count>0, pop the entry into a 32-bit shift register, set byte_idx=0, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: txd = current byte bit[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then, if byte_idx<3, increment byte_idx and go to START with no gap; else go to IDLE.
- Byte order: nonce[7:0] first, then [15:8], [23:16], [31:24] (little-endian).
- Latency:
  - Strobe sampled at edge E0 while idle with an empty FIFO → pop at E1 → txd falls after E1.
  - One nonce frame = 40*CLKS_PER_BIT cycles.
  - After the final stop bit, the FSM spends exactly one cycle in IDLE before the next pop, so consecutive nonces are spaced 40*CLKS_PER_BIT+1 cycles.
- busy = (state!=IDLE) | (fifo_count!=0), registered from the next-state values, so it is glitch-free.
- Bit timer: a down-counter reloaded with CLKS_PER_BIT-1 on every bit boundary. No cumulative drift is permitted: bit k edge is at exactly start + k*CLKS_PER_BIT.
- golden_nonce_match held high for multiple cycles is treated as multiple strobes; each cycle writes one entry.
- golden_nonce is ignored when the strobe is low.

Test Plan:
- CLKS_PER_BIT=4, FIFO_DEPTH=4; single strobe with 32'hffbd9207 at cycle 10:
  - txd low from cycle 12.
  - Decoded bytes 07, 92, bd, ff, each framed start=0 / stop=1.
  - txd high and busy=0 at cycle 12+160+1.
- Five strobes on consecutive cycles (32'h1, 32'h2, 32'h3, 32'h4, 32'h5) while idle:
  - The first is popped immediately, so all five are accepted and overflow stays 0.
  - Frames carry nonces 1–5 in order, 161 cycles apart.
- Six consecutive strobes (1–6) while a frame is already in flight:
  - Nonces 1–4 are queued; 5 and 6 are dropped; overflow=1 from the fifth strobe's edge.
  - Output sequence is exactly 1, 2, 3, 4.
- FIFO full (4 queued), strobe on the same edge as the IDLE pop: accepted, fifo_count stays 4, overflow stays 0.
- Assert reset during DATA bit 3 of byte 2:
  - txd=1 and busy=0 in the same cycle; fifo_count=0; overflow=0.
  - After release, a new strobe with 32'hdeadbeef transmits ef, be, ad, de cleanly.
- CLKS_PER_BIT=2 (minimum): single nonce 32'h00000000 yields 40 bit periods of exactly 2 cycles each, pattern 0,00000000,1 repeated ×4.
